// File: rtl/alu_issue_ctrl.sv
// Issue/writeback sequencer around a 16-bit combinational ALU: fetches operands
// from an internal register file, drives the ALU, and retires result and flags.
module alu_issue_ctrl #(
    parameter int DATA_W = 16,
    parameter int NREG   = 8,
    parameter int AW     = $clog2(NREG)
) (
    input  logic              clk,
    input  logic              rst,
    // Handshake: an instruction transfers on a rising edge where
    // instr_valid && instr_ready; instr_valid may stay high while busy.
    input  logic              instr_valid,
    output logic              instr_ready,
    input  logic [3:0]        instr_op,
    input  logic [AW-1:0]     instr_rd,
    input  logic [AW-1:0]     instr_rs1,
    input  logic [AW-1:0]     instr_rs2,
    input  logic [DATA_W-1:0] instr_imm,
    output logic [DATA_W-1:0] alu_a,
    output logic [DATA_W-1:0] alu_b,
    output logic [3:0]        alu_fn,
    input  logic [DATA_W-1:0] alu_d,
    input  logic              alu_z,
    input  logic              alu_c,
    input  logic              alu_n,
    input  logic              alu_v,
    output logic              done,
    output logic              err,
    output logic [3:0]        flags_q,
    output logic              busy,
    input  logic [AW-1:0]     dbg_addr,
    output logic [DATA_W-1:0] dbg_data,
    output logic [1:0]        dbg_state
);

    localparam logic [3:0] OP_ADD = 4'b0000;
    localparam logic [3:0] OP_SUB = 4'b0001;
    localparam logic [3:0] OP_MUL = 4'b0010;
    localparam logic [3:0] OP_DIV = 4'b0011;
    localparam logic [3:0] OP_LDI = 4'b1111;

    typedef enum logic [1:0] {IDLE, READ, EXEC, WB} state_t;

    state_t              state, state_next;
    logic [DATA_W-1:0]   rf [NREG];
    logic [3:0]          op_q;
    logic [AW-1:0]       rd_q, rs1_q, rs2_q;
    logic [DATA_W-1:0]   imm_q;
    logic [DATA_W-1:0]   res;
    logic [3:0]          fl;
    logic                bad;
    logic                op_legal;

    assign op_legal = (op_q == OP_ADD) || (op_q == OP_SUB) || (op_q == OP_MUL) ||
                      (op_q == OP_DIV) || (op_q == OP_LDI);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    always_comb begin
        state_next  = state;
        instr_ready = 1'b0;
        done        = 1'b0;
        err         = 1'b0;
        case (state)
            IDLE: begin
                instr_ready = !rst;
                if (instr_valid && !rst) state_next = READ;
            end
            READ: state_next = EXEC;
            EXEC: state_next = WB;
            WB: begin
                done       = !bad;
                err        = bad;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    assign busy      = (state != IDLE);
    assign dbg_state = state;
    assign dbg_data  = rf[dbg_addr];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            op_q    <= '0;
            rd_q    <= '0;
            rs1_q   <= '0;
            rs2_q   <= '0;
            imm_q   <= '0;
            alu_a   <= '0;
            alu_b   <= '0;
            alu_fn  <= '0;
            bad     <= 1'b0;
            res     <= '0;
            fl      <= '0;
            flags_q <= '0;
            for (int i = 0; i < NREG; i++) rf[i] <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (instr_valid) begin
                        op_q  <= instr_op;
                        rd_q  <= instr_rd;
                        rs1_q <= instr_rs1;
                        rs2_q <= instr_rs2;
                        imm_q <= instr_imm;
                    end
                end
                READ: begin
                    alu_a  <= rf[rs1_q];
                    alu_b  <= rf[rs2_q];
                    alu_fn <= op_q;
                    bad    <= !op_legal || ((op_q == OP_DIV) && (rf[rs2_q] == '0));
                end
                EXEC: begin
                    res <= alu_d;
                    fl  <= {alu_z, alu_c, alu_n, alu_v};
                end
                WB: begin
                    // LDI writes the immediate and leaves the status flags alone.
                    if (!bad) begin
                        if (op_q == OP_LDI) begin
                            rf[rd_q] <= imm_q;
                        end else begin
                            rf[rd_q] <= res;
                            flags_q  <= fl;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Bench for alu_issue_ctrl: behavioural ALU, register-file model and a
// scoreboard of expected writebacks checked as each instruction retires.
module tb_alu_issue_ctrl;

    localparam logic [3:0] OP_ADD = 4'b0000;
    localparam logic [3:0] OP_SUB = 4'b0001;
    localparam logic [3:0] OP_MUL = 4'b0010;
    localparam logic [3:0] OP_DIV = 4'b0011;
    localparam logic [3:0] OP_LDI = 4'b1111;

    logic        clk = 1'b0;
    logic        rst;
    logic        instr_valid, instr_ready;
    logic [3:0]  instr_op;
    logic [2:0]  instr_rd, instr_rs1, instr_rs2;
    logic [15:0] instr_imm;
    logic [15:0] alu_a, alu_b, alu_d;
    logic [3:0]  alu_fn;
    logic        alu_z, alu_c, alu_n, alu_v;
    logic        done, err, busy;
    logic [3:0]  flags_q;
    logic [2:0]  dbg_addr;
    logic [15:0] dbg_data;
    logic [1:0]  dbg_state;

    int checks = 0;
    int errors = 0;

    logic [15:0] model_rf [8];
    logic [3:0]  model_fl;
    logic [15:0] exp_q[$];
    logic [3:0]  exp_fl_q[$];
    logic        exp_err_q[$];
    logic [2:0]  exp_rd_q[$];

    alu_issue_ctrl dut (
        .clk(clk), .rst(rst),
        .instr_valid(instr_valid), .instr_ready(instr_ready),
        .instr_op(instr_op), .instr_rd(instr_rd), .instr_rs1(instr_rs1),
        .instr_rs2(instr_rs2), .instr_imm(instr_imm),
        .alu_a(alu_a), .alu_b(alu_b), .alu_fn(alu_fn), .alu_d(alu_d),
        .alu_z(alu_z), .alu_c(alu_c), .alu_n(alu_n), .alu_v(alu_v),
        .done(done), .err(err), .flags_q(flags_q), .busy(busy),
        .dbg_addr(dbg_addr), .dbg_data(dbg_data), .dbg_state(dbg_state)
    );

    // clock / reset
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, required completion");
        $fatal(1, "watchdog");
    end

    // Returns {d[15:0], z, c, n, v}.
    function automatic logic [19:0] alu_ref(input logic [3:0] fn, input logic [15:0] a,
                                            input logic [15:0] b);
        logic [16:0] s;
        logic [31:0] p;
        logic [15:0] d;
        logic        c, v;
        d = '0; c = 1'b0; v = 1'b0;
        case (fn)
            OP_ADD: begin
                s = {1'b0, a} + {1'b0, b};
                d = s[15:0]; c = s[16];
                v = (a[15] == b[15]) && (d[15] != a[15]);
            end
            OP_SUB: begin
                d = a - b; c = (a >= b);
                v = (a[15] != b[15]) && (d[15] != a[15]);
            end
            OP_MUL: begin
                p = a * b; d = p[15:0]; c = |p[31:16];
            end
            OP_DIV: begin
                if (b == 16'h0) begin d = 16'hFFFF; v = 1'b1; end
                else d = a / b;
            end
            default: d = '0;
        endcase
        return {d, (d == 16'h0), c, d[15], v};
    endfunction

    function automatic logic is_legal(input logic [3:0] op);
        return (op == OP_ADD) || (op == OP_SUB) || (op == OP_MUL) ||
               (op == OP_DIV) || (op == OP_LDI);
    endfunction

    always_comb begin
        {alu_d, alu_z, alu_c, alu_n, alu_v} = alu_ref(alu_fn, alu_a, alu_b);
    end

    // driver tasks
    task automatic wait_ready();
        int n;
        n = 0;
        while (!instr_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (!instr_ready) begin
            errors++;
            $display("FAIL wait_ready: instr_ready=%b after %0d cycles, required 1", instr_ready, n);
        end
    endtask

    task automatic run_instr(input logic [3:0] op, input logic [2:0] rd, input logic [2:0] rs1,
                             input logic [2:0] rs2, input logic [15:0] imm);
        logic [19:0] r;
        logic        bad;
        logic [15:0] old_d, e_d;
        logic [3:0]  e_f;
        logic        e_err;
        int          lat;
        r     = alu_ref(op, model_rf[rs1], model_rf[rs2]);
        bad   = !is_legal(op) || ((op == OP_DIV) && (model_rf[rs2] == 16'h0));
        old_d = model_rf[rd];
        exp_err_q.push_back(bad);
        if (bad) begin
            exp_q.push_back(old_d); exp_fl_q.push_back(model_fl);
        end else if (op == OP_LDI) begin
            exp_q.push_back(imm); exp_fl_q.push_back(model_fl);
        end else begin
            exp_q.push_back(r[19:4]); exp_fl_q.push_back(r[3:0]);
        end
        wait_ready();
        dbg_addr  = rd;
        instr_op  = op; instr_rd = rd; instr_rs1 = rs1; instr_rs2 = rs2; instr_imm = imm;
        instr_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        instr_valid = 1'b0;
        lat = 1;
        while (!(done || err) && lat < 8) begin
            @(negedge clk);
            lat++;
        end
        e_d = exp_q.pop_front(); e_f = exp_fl_q.pop_front(); e_err = exp_err_q.pop_front();
        checks++;
        if (lat != 3) begin
            errors++;
            $display("FAIL latency op=%b: got %0d cycles, required 3", op, lat);
        end
        checks++;
        if (err !== e_err || done !== !e_err) begin
            errors++;
            $display("FAIL wb_pulse op=%b: done=%b err=%b, required done=%b err=%b",
                     op, done, err, !e_err, e_err);
        end
        checks++;
        if (dbg_data !== old_d) begin
            errors++;
            $display("FAIL early_write r%0d: got %h during WB, required %h", rd, dbg_data, old_d);
        end
        @(negedge clk);
        checks++;
        if (dbg_data !== e_d) begin
            errors++;
            $display("FAIL result r%0d op=%b: got %h, required %h", rd, op, dbg_data, e_d);
        end
        checks++;
        if (flags_q !== e_f) begin
            errors++;
            $display("FAIL flags op=%b: got %b, required %b", op, flags_q, e_f);
        end
        checks++;
        if (instr_ready !== 1'b1 || done !== 1'b0 || err !== 1'b0) begin
            errors++;
            $display("FAIL after_wb op=%b: ready=%b done=%b err=%b, required 1 0 0",
                     op, instr_ready, done, err);
        end
        model_rf[rd] = e_d;
        model_fl     = e_f;
    endtask

    // tests
    task automatic test_reset();
        rst = 1'b1;
        instr_valid = 1'b0; instr_op = '0; instr_rd = '0; instr_rs1 = '0; instr_rs2 = '0;
        instr_imm = '0; dbg_addr = '0;
        for (int i = 0; i < 8; i++) model_rf[i] = '0;
        model_fl = '0;
        repeat (3) @(negedge clk);
        checks++;
        if ({instr_ready, busy, done, err} !== 4'b0000 || alu_a !== 16'h0 || alu_b !== 16'h0 ||
            alu_fn !== 4'h0 || flags_q !== 4'h0) begin
            errors++;
            $display("FAIL reset_outputs: ready=%b busy=%b done=%b err=%b a=%h b=%h fn=%h fl=%b, required all 0",
                     instr_ready, busy, done, err, alu_a, alu_b, alu_fn, flags_q);
        end
        for (int i = 0; i < 8; i++) begin
            dbg_addr = 3'(i);
            #1;
            checks++;
            if (dbg_data !== 16'h0) begin
                errors++;
                $display("FAIL reset_rf r%0d: got %h, required 0000", i, dbg_data);
            end
        end
        @(negedge clk);
        rst = 1'b0;
        #1;
        checks++;
        if (instr_ready !== 1'b1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_release: ready=%b busy=%b, required 1 0", instr_ready, busy);
        end
    endtask

    task automatic test_ldi_add();
        run_instr(OP_LDI, 3'd1, 3'd0, 3'd0, 16'h0005);
        run_instr(OP_LDI, 3'd2, 3'd0, 3'd0, 16'h0003);
        run_instr(OP_ADD, 3'd3, 3'd1, 3'd2, 16'hFFFF);
        checks++;
        if (dbg_data !== 16'h0008 || flags_q !== 4'b0000) begin
            errors++;
            $display("FAIL add_5_3: r3=%h flags=%b, required 0008 0000", dbg_data, flags_q);
        end
    endtask

    task automatic test_sub_mul();
        run_instr(OP_SUB, 3'd4, 3'd2, 3'd2, 16'h0);
        checks++;
        if (dbg_data !== 16'h0000 || flags_q[3] !== 1'b1) begin
            errors++;
            $display("FAIL sub_zero: r4=%h Z=%b, required 0000 1", dbg_data, flags_q[3]);
        end
        run_instr(OP_SUB, 3'd6, 3'd1, 3'd2, 16'h0);      // 5-3: operand order matters
        run_instr(OP_LDI, 3'd3, 3'd0, 3'd0, 16'h7FFF);
        run_instr(OP_ADD, 3'd3, 3'd3, 3'd3, 16'h0);      // rd==rs, signed overflow
        run_instr(OP_DIV, 3'd4, 3'd3, 3'd2, 16'h0);      // 0xFFFE / 3
        run_instr(OP_LDI, 3'd1, 3'd0, 3'd0, 16'h0100);
        run_instr(OP_MUL, 3'd5, 3'd1, 3'd1, 16'h0);
        checks++;
        if (dbg_data !== 16'h0000) begin
            errors++;
            $display("FAIL mul_low16: r5=%h, required 0000", dbg_data);
        end
    endtask

    task automatic test_err();
        run_instr(OP_DIV, 3'd6, 3'd1, 3'd0, 16'h0);
        run_instr(4'b0111, 3'd6, 3'd1, 3'd2, 16'h1234);
        checks++;
        if (dbg_data !== 16'h0002) begin
            errors++;
            $display("FAIL err_no_write: r6=%h, required 0002", dbg_data);
        end
    endtask

    task automatic test_back_to_back();
        logic [2:0]  rds  [4];
        logic [15:0] imms [4];
        int          idx, n_hs, n_done, last_hs;
        logic        hs, pend;
        logic [15:0] pend_d;
        rds  = '{3'd1, 3'd2, 3'd4, 3'd5};
        imms = '{16'hA001, 16'hB002, 16'hC004, 16'hD005};
        wait_ready();
        idx = 0; n_hs = 0; n_done = 0; last_hs = 0; pend = 1'b0; pend_d = '0;
        instr_op = OP_LDI; instr_rd = rds[0]; instr_imm = imms[0];
        instr_valid = 1'b1;
        for (int cyc = 0; cyc < 40 && n_done < 4; cyc++) begin
            if (pend) begin
                checks++;
                if (dbg_data !== pend_d) begin
                    errors++;
                    $display("FAIL b2b_write r%0d: got %h, required %h", dbg_addr, dbg_data, pend_d);
                end
                pend = 1'b0;
            end
            checks++;
            if (instr_ready !== !busy || err !== 1'b0) begin
                errors++;
                $display("FAIL b2b_ready cyc%0d: ready=%b busy=%b err=%b, required ready=!busy err=0",
                         cyc, instr_ready, busy, err);
            end
            if (done) begin
                n_done++;
                pend_d   = exp_q.pop_front();
                dbg_addr = exp_rd_q.pop_front();
                pend     = 1'b1;
            end
            hs = instr_ready && instr_valid;
            if (hs) begin
                if (n_hs > 0) begin
                    checks++;
                    if (cyc - last_hs != 4) begin
                        errors++;
                        $display("FAIL b2b_spacing: got %0d cycles, required 4", cyc - last_hs);
                    end
                end
                last_hs = cyc;
                n_hs++;
                exp_q.push_back(imms[idx]);
                exp_rd_q.push_back(rds[idx]);
            end
            @(negedge clk);
            if (hs) begin
                idx++;
                if (idx < 4) begin
                    instr_rd = rds[idx]; instr_imm = imms[idx];
                end else begin
                    instr_valid = 1'b0;
                end
            end
        end
        @(negedge clk);
        checks++;
        if (!pend || dbg_data !== pend_d) begin
            errors++;
            $display("FAIL b2b_last_write: pending=%b got %h, required 1 %h", pend, dbg_data, pend_d);
        end
        checks++;
        if (n_hs != 4 || n_done != 4) begin
            errors++;
            $display("FAIL b2b_count: handshakes=%0d dones=%0d, required 4 4", n_hs, n_done);
        end
        for (int i = 0; i < 4; i++) model_rf[rds[i]] = imms[i];
        for (int i = 0; i < 8; i++) begin
            dbg_addr = 3'(i);
            #1;
            checks++;
            if (dbg_data !== model_rf[i]) begin
                errors++;
                $display("FAIL b2b_rf r%0d: got %h, required %h", i, dbg_data, model_rf[i]);
            end
        end
    endtask

    task automatic test_reset_mid_op();
        wait_ready();
        dbg_addr = 3'd7;
        instr_op = OP_ADD; instr_rd = 3'd7; instr_rs1 = 3'd1; instr_rs2 = 3'd2;
        instr_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        instr_valid = 1'b0;
        @(negedge clk);
        checks++;
        if (dbg_state !== 2'd2) begin
            errors++;
            $display("FAIL mid_exec_state: got %0d, required 2", dbg_state);
        end
        rst = 1'b1;
        #1;
        checks++;
        if ({instr_ready, busy, done, err} !== 4'b0000 || alu_a !== 16'h0 || alu_fn !== 4'h0) begin
            errors++;
            $display("FAIL mid_reset_outputs: ready=%b busy=%b done=%b err=%b a=%h fn=%h, required all 0",
                     instr_ready, busy, done, err, alu_a, alu_fn);
        end
        @(posedge clk);
        @(negedge clk);
        checks++;
        if (dbg_data !== 16'h0 || flags_q !== 4'h0 || done !== 1'b0 || err !== 1'b0) begin
            errors++;
            $display("FAIL mid_reset_state: r7=%h flags=%b done=%b err=%b, required 0000 0000 0 0",
                     dbg_data, flags_q, done, err);
        end
        for (int i = 0; i < 8; i++) model_rf[i] = '0;
        model_fl = '0;
        rst = 1'b0;
        #1;
        checks++;
        if (instr_ready !== 1'b1) begin
            errors++;
            $display("FAIL mid_reset_release: ready=%b, required 1", instr_ready);
        end
        run_instr(OP_LDI, 3'd7, 3'd0, 3'd0, 16'h1234);
        run_instr(OP_ADD, 3'd6, 3'd7, 3'd7, 16'h0);
    endtask

    initial begin
        test_reset();
        test_ldi_add();
        test_sub_mul();
        test_err();
        test_back_to_back();
        test_reset_mid_op();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
